// File: rtl/seg_scan_driver_if.sv
// seg_scan_driver_if: load/image inputs and scan outputs of the eight-digit seven-segment driver.
interface seg_scan_driver_if;
    logic [31:0] value;
    logic [7:0]  digit_en;
    logic [7:0]  dp;
    logic        load;
    logic [7:0]  display;
    logic [7:0]  anode;
    logic [2:0]  digit_idx;
    logic        frame_done;
    modport master (output value, digit_en, dp, load, input display, anode, digit_idx, frame_done);
    modport slave  (input value, digit_en, dp, load, output display, anode, digit_idx, frame_done);
endinterface

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed eight-digit hex display scanner with blanking and frame-synchronous image reload.
module seg_scan_driver #(
    parameter int DIV   = 100000,
    parameter int BLANK = 16
) (
    input logic              clk,
    input logic              rst,
    seg_scan_driver_if.slave bus
);
    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    typedef enum logic {S_BLANK, S_DRIVE} state_t;
    localparam state_t S_RST = (BLANK > 0) ? S_BLANK : S_DRIVE;

    state_t        r_state, w_state_nx;
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic [2:0]    r_idx;
    logic [31:0]   r_val, r_stg_val;
    logic [7:0]    r_en, r_stg_en, r_dp, r_stg_dp;
    logic          r_pend;
    logic [7:0]    r_disp, r_anode;
    logic [2:0]    r_didx;
    logic          r_fd;
    logic          w_wrap, w_bnd, w_lit;
    logic [3:0]    w_nib;
    logic [6:0]    w_seg;

    assign w_wrap = r_cnt == CW'(DIV - 1);
    assign w_bnd  = w_wrap && r_idx == 3'd7;
    assign w_nib  = r_val[{r_idx, 2'b00} +: 4];

    always_comb begin
        w_cnt_nx   = w_wrap ? '0 : r_cnt + CW'(1);
        w_state_nx = (int'(w_cnt_nx) < BLANK) ? S_BLANK : S_DRIVE;
        w_lit      = r_state == S_DRIVE && r_en[r_idx];
        w_seg      = 7'h7F;
        case (w_nib)
            4'h0: w_seg = 7'h40;
            4'h1: w_seg = 7'h79;
            4'h2: w_seg = 7'h24;
            4'h3: w_seg = 7'h30;
            4'h4: w_seg = 7'h19;
            4'h5: w_seg = 7'h12;
            4'h6: w_seg = 7'h02;
            4'h7: w_seg = 7'h78;
            4'h8: w_seg = 7'h00;
            4'h9: w_seg = 7'h10;
            4'hA: w_seg = 7'h08;
            4'hB: w_seg = 7'h03;
            4'hC: w_seg = 7'h46;
            4'hD: w_seg = 7'h21;
            4'hE: w_seg = 7'h06;
            4'hF: w_seg = 7'h0E;
            default: w_seg = 7'h7F;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RST;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_idx   <= w_wrap ? r_idx + 3'd1 : r_idx;
        end
    end

    // A Load on the boundary cycle bypasses staging and wins over any older pending image
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_val     <= '0;
            r_en      <= '0;
            r_dp      <= '0;
            r_stg_val <= '0;
            r_stg_en  <= '0;
            r_stg_dp  <= '0;
            r_pend    <= 1'b0;
        end else if (w_bnd) begin
            r_pend <= 1'b0;
            if (bus.load) begin
                r_val <= bus.value;
                r_en  <= bus.digit_en;
                r_dp  <= bus.dp;
            end else if (r_pend) begin
                r_val <= r_stg_val;
                r_en  <= r_stg_en;
                r_dp  <= r_stg_dp;
            end
        end else if (bus.load) begin
            r_stg_val <= bus.value;
            r_stg_en  <= bus.digit_en;
            r_stg_dp  <= bus.dp;
            r_pend    <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_disp  <= 8'hFF;
            r_anode <= 8'hFF;
            r_didx  <= '0;
            r_fd    <= 1'b0;
        end else begin
            r_disp  <= w_lit ? {~r_dp[r_idx], w_seg} : 8'hFF;
            r_anode <= w_lit ? ~(8'h01 << r_idx) : 8'hFF;
            r_didx  <= r_idx;
            r_fd    <= w_bnd;
        end
    end

    assign bus.display    = r_disp;
    assign bus.anode      = r_anode;
    assign bus.digit_idx  = r_didx;
    assign bus.frame_done = r_fd;
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed frames against a cycle model; expected outputs queued at drive time and checked after each edge.
module tb_seg_scan_driver;
    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct packed {
        logic [7:0] ds;
        logic [7:0] an;
        logic [2:0] ix;
        logic       fd;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    seg_scan_driver_if bus ();

    seg_scan_driver #(.DIV(DIV), .BLANK(BLANK)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    exp_t        q[$];
    int          n_chk = 0, n_fail = 0;
    int          m_cnt, m_idx;
    logic [31:0] m_val, s_val;
    logic [7:0]  m_en, m_dp, s_en, s_dp;
    bit          m_pend;
    int          n_step = 0, last_fd = -1;
    int          n_lit, n_fd, na, nb;
    logic [7:0]  pa_an, pa_ds, pb_an, pb_ds;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_idx = 0; m_pend = 0;
        m_val = '0; m_en = '0; m_dp = '0; s_val = '0; s_en = '0; s_dp = '0;
        last_fd = -1;
    endtask

    task automatic pat(input logic [7:0] a_an, input logic [7:0] a_ds, input logic [7:0] b_an, input logic [7:0] b_ds);
        pa_an = a_an; pa_ds = a_ds; pb_an = b_an; pb_ds = b_ds;
        n_lit = 0; n_fd = 0; na = 0; nb = 0;
    endtask

    task automatic step();
        exp_t       e;
        bit         bnd, lit;
        logic [3:0] nib;
        lit  = (m_cnt >= BLANK) && m_en[m_idx];
        nib  = m_val[m_idx*4 +: 4];
        e.an = lit ? ~(8'h01 << m_idx) : 8'hFF;
        e.ds = lit ? {~m_dp[m_idx], HEX[nib]} : 8'hFF;
        e.ix = 3'(m_idx);
        bnd  = (m_idx == 7) && (m_cnt == DIV - 1);
        e.fd = bnd;
        q.push_back(e);
        if (bnd) begin
            if (bus.load) begin
                m_val = bus.value; m_en = bus.digit_en; m_dp = bus.dp;
            end else if (m_pend) begin
                m_val = s_val; m_en = s_en; m_dp = s_dp;
            end
            m_pend = 0;
        end else if (bus.load) begin
            s_val = bus.value; s_en = bus.digit_en; s_dp = bus.dp; m_pend = 1;
        end
        if (m_cnt == DIV - 1) begin
            m_cnt = 0;
            m_idx = (m_idx + 1) % 8;
        end else m_cnt++;
        @(posedge clk);
        #1;
        n_step++;
        e = q.pop_front();
        chk("display", 32'(bus.display), 32'(e.ds));
        chk("anode", 32'(bus.anode), 32'(e.an));
        chk("digit_idx", 32'(bus.digit_idx), 32'(e.ix));
        chk("frame_done", 32'(bus.frame_done), 32'(e.fd));
        if (bus.anode != 8'hFF) n_lit++;
        if (bus.anode == pa_an && bus.display == pa_ds) na++;
        if (bus.anode == pb_an && bus.display == pb_ds) nb++;
        if (bus.frame_done) begin
            n_fd++;
            if (last_fd >= 0) chk("fd_gap", 32'(n_step - last_fd), 32'd64);
            last_fd = n_step;
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic ld(input logic [31:0] v, input logic [7:0] en, input logic [7:0] d);
        bus.value = v; bus.digit_en = en; bus.dp = d; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, "_anode"}, 32'(bus.anode), 32'hFF);
        chk({tag, "_display"}, 32'(bus.display), 32'hFF);
        chk({tag, "_idx"}, 32'(bus.digit_idx), 32'h0);
        chk({tag, "_fd"}, 32'(bus.frame_done), 32'h0);
    endtask

    task automatic frame_chk(input string tag, input int e_lit, input int e_a, input int e_b);
        chk({tag, "_lit"}, 32'(n_lit), 32'(e_lit));
        chk({tag, "_a"}, 32'(na), 32'(e_a));
        chk({tag, "_b"}, 32'(nb), 32'(e_b));
    endtask

    initial begin
        bus.value = '0; bus.digit_en = '0; bus.dp = '0; bus.load = 1'b0;
        model_reset();
        pat(8'h00, 8'h00, 8'h00, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        rst_chk("rst_hold");
        rst = 1'b0;

        run(128);
        chk("idle_lit", 32'(n_lit), 32'd0);
        chk("idle_fd", 32'(n_fd), 32'd2);

        pat(8'h00, 8'h00, 8'h00, 8'h00);
        run(10);
        ld(32'h76543210, 8'hFF, 8'h00);
        run(53);
        chk("midframe_hold", 32'(n_lit), 32'd0);
        pat(8'hFE, 8'hC0, 8'h7F, 8'hF8);
        run(64);
        frame_chk("img_a", 48, 6, 6);

        run(5);
        ld(32'h00000F8A, 8'h05, 8'h04);
        run(58);
        pat(8'hFE, 8'h88, 8'hFB, 8'h0E);
        run(64);
        frame_chk("sparse", 12, 6, 6);

        run(3);
        ld(32'h11111111, 8'hFF, 8'h00);
        run(20);
        ld(32'h22222222, 8'h81, 8'h81);
        run(39);
        pat(8'hFE, 8'h24, 8'h7F, 8'h24);
        run(64);
        frame_chk("last_wins", 12, 6, 6);

        run(2);
        ld(32'h12345678, 8'hFF, 8'h00);
        run(60);
        ld(32'hFFFFFFFF, 8'hFF, 8'h00);
        pat(8'hFE, 8'h8E, 8'h7F, 8'h8E);
        run(64);
        frame_chk("bnd_load", 48, 6, 6);
        pat(8'hFE, 8'h8E, 8'h7F, 8'h8E);
        run(64);
        frame_chk("bnd_nopend", 48, 6, 6);

        run(3);
        ld(32'h00000000, 8'hFF, 8'hFF);
        run(31);
        chk("pre_rst_anode", 32'(bus.anode), 32'hEF);
        #3 rst = 1'b1;
        #1 rst_chk("rst_async");
        @(posedge clk);
        @(posedge clk);
        #1 rst_chk("rst_mid");
        rst = 1'b0;
        model_reset();
        pat(8'h00, 8'h00, 8'h00, 8'h00);
        run(128);
        chk("post_rst_lit", 32'(n_lit), 32'd0);
        chk("post_rst_fd", 32'(n_fd), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
